// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state encoding and fault codes for the phase sequencer
//
// Contents:
//   OP_*          RV32I major opcodes recognised by the sequencer
//   state_e       phase FSM encoding (also visible on the debug state port)
//   fault_e       fault_cause codes
//   TIMER_W       width of the memory wait timer (covers TIMEOUT up to 255)
//   is_legal_op   opcode is one the core can execute
//   is_mem_op     opcode needs a data-memory phase
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_ERROR     = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_ILLEGAL  = 2'b01,
        FC_MISALIGN = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fault_e;

    localparam int TIMER_W = 8;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - handshake wait timer shared by the fetch and memory phases
//
// Ports:
//   clk     core clock
//   rst     synchronous active-high reset
//   clear   zero the count (takes priority over enable)
//   enable  one more cycle spent waiting for an ack
//   expire  this edge is the one on which the wait count reaches TIMEOUT
module seq_wait_timer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Combinational so the FSM can leave on the very edge the count would
    // reach TIMEOUT; an ack on that edge drops enable and so suppresses it.
    assign expire = enable && (count_q == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK controller for the RV32I core
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   run              level enable; 0 stops at the next instruction boundary
//   instr_in         instruction ROM read data
//   imem_ack         ROM data valid (sampled in FETCH)
//   dmem_ack         RAM access complete (sampled in MEM)
//   branch_taken     PC select from the control unit, valid in EXECUTE
//   alu_result       branch/jump target, valid in EXECUTE
//   regwen_dec       decoded register write enable for the current ir
//   pc, ir           current instruction address and latched instruction
//   imem_req         ROM read request
//   dmem_req         RAM access request, dmem_we = store
//   rf_we, pc_we     one-cycle register-file / PC update strobes
//   state            FSM encoding for debug
//   busy             high in all states except IDLE and ERROR
//   error            sticky fault flag, fault_cause = reason
//   retired          retired-instruction counter
module cpu_phase_sequencer
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [31:0]     instr_in,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] alu_result,
    input  logic            regwen_dec,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     ir,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            rf_we,
    output logic            pc_we,
    output logic [2:0]      state,
    output logic            busy,
    output logic            error,
    output logic [1:0]      fault_cause,
    output logic [31:0]     retired
);

    state_e          state_q,   state_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic [31:0]     ir_q,      ir_d;
    logic [31:0]     retired_q, retired_d;
    fault_e          cause_q,   cause_d;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic       waiting;
    logic       ack_now;
    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expire;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];

    // The timer only runs while a request is outstanding and unanswered;
    // any ack or any other phase restarts it from zero.
    assign waiting      = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign ack_now      = (state_q == ST_FETCH) ? imem_ack : dmem_ack;
    assign timer_enable = waiting && !ack_now;
    assign timer_clear  = !waiting || ack_now;

    seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = instr_in;
                    state_d = ST_DECODE;
                end else if (timer_expire) begin
                    cause_d = FC_TIMEOUT;
                    state_d = ST_ERROR;
                end
            end

            ST_DECODE: begin
                if (!is_legal_op(opcode)) begin
                    cause_d = FC_ILLEGAL;
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                // Target is captured here because alu_result/branch_taken
                // are only meaningful while ir is being executed.
                next_pc_d = branch_taken ? alu_result : pc_q + XLEN'(4);
                if (branch_taken && (alu_result[1:0] != 2'b00)) begin
                    cause_d = FC_MISALIGN;
                    state_d = ST_ERROR;
                end else if (is_mem_op(opcode)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ack) begin
                    state_d = ST_WRITEBACK;
                end else if (timer_expire) begin
                    cause_d = FC_TIMEOUT;
                    state_d = ST_ERROR;
                end
            end

            ST_WRITEBACK: begin
                pc_we     = 1'b1;
                pc_d      = next_pc_q;
                // Stores and branches have no rd; x0 is never written.
                rf_we     = regwen_dec && (rd != 5'd0) &&
                            (opcode != OP_STORE) && (opcode != OP_BRANCH);
                retired_d = retired_q + 32'd1;
                state_d   = run ? ST_FETCH : ST_IDLE;
            end

            ST_ERROR: begin
                state_d = ST_ERROR;
            end

            default: begin
                // Unused encoding: treat as corruption and park.
                state_d = ST_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
            cause_q   <= FC_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign state       = state_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign error       = (state_q == ST_ERROR);
    assign fault_cause = cause_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb/tb_cpu_phase_sequencer.sv - randomized self-checking bench for cpu_phase_sequencer
module tb_cpu_phase_sequencer;
    import cpu_pkg::*;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] instr_in;
    logic        imem_ack;
    logic        dmem_ack;
    logic        branch_taken;
    logic [31:0] alu_result;
    logic        regwen_dec;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        pc_we;
    logic [2:0]  state;
    logic        busy;
    logic        error;
    logic [1:0]  fault_cause;
    logic [31:0] retired;

    cpu_phase_sequencer #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .instr_in     (instr_in),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .branch_taken (branch_taken),
        .alu_result   (alu_result),
        .regwen_dec   (regwen_dec),
        .pc           (pc),
        .ir           (ir),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .state        (state),
        .busy         (busy),
        .error        (error),
        .fault_cause  (fault_cause),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_retired;
    logic [31:0] m_ir;

    logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                  OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; instr_in = '0; imem_ack = 1'b0; dmem_ack = 1'b0;
        branch_taken = 1'b0; alu_result = '0; regwen_dec = 1'b0;
        step();
        step();
        check_eq("rst_ctrl", {state, error, fault_cause, imem_req, dmem_req, dmem_we,
                              rf_we, pc_we, busy}, 32'd0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_ir", ir, 32'h0);
        check_eq("rst_retired", retired, 32'h0);
        rst = 1'b0;
        m_pc = 32'h0; m_retired = 32'h0; m_ir = 32'h0;
    endtask

    task automatic start_run();
        run = 1'b1;
        step();
        check_eq("enter_fetch", state, 32'd1);
    endtask

    function automatic bit legal(input logic [6:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Runs one instruction from a FETCH-cycle negedge and compares the whole
    // observed episode against what the phase rules predict.
    task automatic exec_instr(input logic [31:0] instr, input int iack_dly, input int dack_dly,
                              input bit taken, input logic [31:0] target, input bit regwen,
                              input bit drop_run, output bit faulted);
        logic [6:0]  op;
        bit          mem_op;
        int          exp_cycles, exp_mem_cyc;
        logic [1:0]  exp_cause;
        bit          exp_rf;
        logic [31:0] exp_next_pc;
        int          busy_cyc, icnt, dcnt, rf_cnt, pcwe_cnt, dreq_cnt, dwe_cnt;
        bit          done, wb_seen;

        op     = instr[6:0];
        mem_op = (op == OP_LOAD) || (op == OP_STORE);
        exp_mem_cyc = 0;
        if (iack_dly >= TMO) begin
            exp_cause = 2'b11; exp_cycles = TMO;
        end else if (!legal(op)) begin
            exp_cause = 2'b01; exp_cycles = iack_dly + 2;
        end else if (taken && target[1:0] != 2'b00) begin
            exp_cause = 2'b10; exp_cycles = iack_dly + 3;
        end else if (mem_op && dack_dly >= TMO) begin
            exp_cause = 2'b11; exp_cycles = iack_dly + 3 + TMO; exp_mem_cyc = TMO;
        end else begin
            exp_cause = 2'b00;
            exp_mem_cyc = mem_op ? dack_dly + 1 : 0;
            exp_cycles = iack_dly + 4 + exp_mem_cyc;
        end
        exp_rf = (exp_cause == 2'b00) && regwen && (instr[11:7] != 5'd0) &&
                 (op != OP_STORE) && (op != OP_BRANCH);
        exp_next_pc = taken ? target : m_pc + 32'd4;

        instr_in = instr; branch_taken = taken; alu_result = target; regwen_dec = regwen;
        check_eq("fetch_pc", pc, m_pc);
        if (drop_run) run = 1'b0;

        busy_cyc = 0; icnt = 0; dcnt = 0; rf_cnt = 0; pcwe_cnt = 0; dreq_cnt = 0; dwe_cnt = 0;
        done = 1'b0; wb_seen = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (error) begin
                done = 1'b1;
            end else begin
                if (busy) busy_cyc++;
                rf_cnt   += int'(rf_we);
                pcwe_cnt += int'(pc_we);
                dreq_cnt += int'(dmem_req);
                dwe_cnt  += int'(dmem_req & dmem_we);
                if (pc_we) wb_seen = 1'b1;
                imem_ack = imem_req && (icnt >= iack_dly);
                if (imem_req) icnt++;
                dmem_ack = dmem_req && (dcnt >= dack_dly);
                if (dmem_req) dcnt++;
                step();
                if (wb_seen) done = 1'b1;
            end
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;

        if (iack_dly < TMO) m_ir = instr;
        check_eq("instr_done", done, 1'b1);
        check_eq("busy_cycles", busy_cyc, exp_cycles);
        check_eq("error", error, exp_cause != 2'b00);
        check_eq("cause", fault_cause, exp_cause);
        check_eq("rf_we_pulses", rf_cnt, exp_rf);
        check_eq("pc_we_pulses", pcwe_cnt, exp_cause == 2'b00);
        check_eq("mem_cycles", dreq_cnt, exp_mem_cyc);
        check_eq("store_cycles", dwe_cnt, (op == OP_STORE) ? exp_mem_cyc : 0);
        check_eq("ir", ir, m_ir);

        faulted = (exp_cause != 2'b00);
        if (!faulted) begin
            m_pc = exp_next_pc;
            m_retired = m_retired + 32'd1;
            check_eq("pc_after", pc, m_pc);
            check_eq("retired", retired, m_retired);
            check_eq("boundary_state", state, drop_run ? 32'd0 : 32'd1);
            if (drop_run) begin
                step();
                step();
                check_eq("idle_hold", {state, imem_req, busy}, 32'd0);
                check_eq("idle_pc", pc, m_pc);
                run = 1'b1;
                step();
                check_eq("resume_fetch", state, 32'd1);
            end
        end else begin
            step();
            step();
            check_eq("sticky_err", {state, error, imem_req, dmem_req, rf_we, pc_we}, 32'h0000_00F0);
            check_eq("frozen_pc", pc, m_pc);
            check_eq("frozen_ret", retired, m_retired);
        end
    endtask

    task automatic rst_in_mem();
        instr_in = 32'h0000_2083; regwen_dec = 1'b1; branch_taken = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        step();
        check_eq("mem_reached", {state, dmem_req}, {28'd0, 3'd4, 1'b1});
        rst = 1'b1;
        step();
        check_eq("mem_abort", {state, dmem_req, busy}, 32'd0);
        check_eq("mem_abort_pc", pc, 32'h0);
        rst = 1'b0;
        m_pc = 32'h0; m_retired = 32'h0; m_ir = 32'h0;
        start_run();
    endtask

    initial begin
        bit          f;
        logic [31:0] r1, r2;
        logic [6:0]  op;
        int          sel, iack, dack;
        bit          tk, rw, drop;
        logic [31:0] tgt, ins;

        do_reset();
        start_run();

        exec_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0, f);          // addi x1,x0,5
        exec_instr(32'h0000_0063, 0, 0, 1'b1, 32'h40, 1'b1, 1'b0, f);         // beq taken
        exec_instr(32'h0000_0063, 0, 0, 1'b1, 32'h42, 1'b0, 1'b0, f);         // misaligned
        do_reset(); start_run();
        exec_instr(32'h0000_2083, 0, 3, 1'b0, 32'h0, 1'b1, 1'b0, f);          // lw, slow ack
        exec_instr(32'h0011_2023, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0, f);          // sw
        exec_instr(32'h0050_0093, 14, 0, 1'b0, 32'h0, 1'b1, 1'b0, f);         // ack on last edge
        exec_instr(32'h0050_0093, 15, 0, 1'b0, 32'h0, 1'b1, 1'b0, f);         // fetch timeout
        do_reset(); start_run();
        exec_instr(32'h0000_007F, 2, 0, 1'b0, 32'h0, 1'b1, 1'b0, f);          // illegal
        do_reset(); start_run();
        exec_instr(32'h0050_0093, 1, 0, 1'b0, 32'h0, 1'b1, 1'b1, f);          // run dropped
        rst_in_mem();
        exec_instr(32'h0000_006F, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, f);  // jal to top
        exec_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0, f);          // pc wraps
        exec_instr(32'h0000_2083, 0, 15, 1'b0, 32'h0, 1'b1, 1'b0, f);         // mem timeout
        do_reset(); start_run();

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 19);
            r1 = $urandom();
            r2 = $urandom();
            if (sel == 0)      op = 7'h7F;
            else if (sel == 1) op = r2[6:0];
            else               op = legal_ops[$urandom_range(0, 8)];
            ins  = {r1[31:7], op};
            iack = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
            dack = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
            if (op == OP_JAL || op == OP_JALR) tk = 1'b1;
            else if (op == OP_BRANCH)          tk = 1'($urandom_range(0, 1));
            else                               tk = 1'b0;
            tgt  = {r2[31:2], ($urandom_range(0, 7) == 0) ? r2[1:0] : 2'b00};
            rw   = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 7) == 0);
            exec_instr(ins, iack, dack, tk, tgt, rw, drop, f);
            if (f) begin
                do_reset();
                start_run();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
